// File: rtl/mpu_lookup_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pkg_mpu : shared MPU types for thread lookup and instruction fetch   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pkg_mpu;

   localparam int MPU_WIDTH_ID    = 8;
   localparam int MPU_WIDTH_ADDR  = 10;
   localparam int MPU_WIDTH_INSTR = 32;

   typedef logic [MPU_WIDTH_ID-1:0]    id_t;
   typedef logic [MPU_WIDTH_ADDR-1:0]  mpu_address_t;
   typedef logic [MPU_WIDTH_INSTR-1:0] instr_t;

   typedef struct packed {
      mpu_address_t address;
      mpu_address_t length;
   } lookup_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      FETCH  = 2'd2,
      DRAIN  = 2'd3
   } fsm_lookup_fetch;

endpackage
`default_nettype wire

// File: rtl/mpu_lookup_fetch_skid.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mpu_fetch_skid : 2-entry FIFO between instruction memory and output  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mpu_fetch_skid
   import pkg_mpu::*;
#(
   parameter int WIDTH = MPU_WIDTH_INSTR
)
(
   input  logic             clock,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic [1:0]       o_count,
   output logic             o_valid
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_rd_ptr;
   logic             r_wr_ptr;
   logic [1:0]       r_count;
   logic             w_pop_ok;
   logic             w_push_ok;

   assign w_pop_ok  = i_pop & (r_count != 2'd0);
   // When full, a push is only taken together with a pop; it lands in the slot being freed.
   assign w_push_ok = i_push & ((r_count != 2'd2) | w_pop_ok);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_valid = (r_count != 2'd0);

endmodule
`default_nettype wire

// File: rtl/mpu_lookup_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mpu_lookup_fetch : dispatch -> map lookup -> instruction stream      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mpu_lookup_fetch
   import pkg_mpu::*;
#(
   parameter int WIDTH_ID    = MPU_WIDTH_ID,
   parameter int WIDTH_ADDR  = MPU_WIDTH_ADDR,
   parameter int WIDTH_INSTR = $bits(instr_t)
)
(
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   I_Req_Dispatch,
   input  logic [WIDTH_ID-1:0]    I_ThreadID,
   output logic                   O_Ack_Dispatch,
   output logic                   O_Req_Lookup,
   output logic [WIDTH_ID-1:0]    O_ThreadID_Ld,
   input  logic                   I_Ack_Lookup,
   input  lookup_t                I_ThreadInfo,
   output logic                   O_IMem_Re,
   output logic [WIDTH_ADDR-1:0]  O_IMem_Addr,
   input  logic [WIDTH_INSTR-1:0] I_IMem_Data,
   output logic                   O_Instr_Valid,
   output logic [WIDTH_INSTR-1:0] O_Instr,
   input  logic                   I_Instr_Ready,
   output logic                   O_Busy,
   output logic                   O_Done
);

   fsm_lookup_fetch        r_state;
   fsm_lookup_fetch        w_state_nxt;
   logic [WIDTH_ADDR-1:0]  r_ptr;
   logic [WIDTH_ADDR-1:0]  r_remaining;
   logic [WIDTH_ID-1:0]    r_thread_id;
   logic                   r_inflight;
   logic                   r_done;

   logic                   w_accept;
   logic                   w_finish;
   logic                   w_pop;
   logic                   w_re;
   logic                   w_drain_empty;
   logic                   w_lookup_hit;
   logic                   w_fifo_valid;
   logic [1:0]             w_fifo_count;
   logic [2:0]             w_occupancy;
   logic [WIDTH_INSTR-1:0] w_fifo_data;

   assign w_pop        = w_fifo_valid & I_Instr_Ready;
   assign w_occupancy  = {1'b0, w_fifo_count} + {2'b00, r_inflight};
   assign w_lookup_hit = (r_state == LOOKUP) && I_Ack_Lookup;

   // Credit: buffered + in-flight words after this cycle's pop must leave room for one more.
   assign w_re = (r_state == FETCH) && (r_remaining != '0) &&
                 (w_occupancy < (3'd2 + {2'b00, w_pop}));

   // Finish on the cycle of the last handshake so O_Done lands right after it.
   assign w_drain_empty = !r_inflight &&
                          ((w_fifo_count == 2'd0) || ((w_fifo_count == 2'd1) && w_pop));

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         IDLE: begin
            if (I_Req_Dispatch) begin
               w_accept    = 1'b1;
               w_state_nxt = LOOKUP;
            end
         end
         LOOKUP: begin
            if (I_Ack_Lookup) begin
               if (I_ThreadInfo.length == '0) begin
                  w_finish    = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = FETCH;
               end
            end
         end
         FETCH: begin
            if (w_re && (r_remaining == WIDTH_ADDR'(1))) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (w_drain_empty) begin
               w_finish    = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_remaining <= '0;
         r_thread_id <= '0;
         r_inflight  <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_inflight <= w_re;
         r_done     <= w_finish;
         if (w_accept) begin
            r_thread_id <= I_ThreadID;
         end
         if (w_lookup_hit) begin
            r_ptr       <= I_ThreadInfo.address;
            r_remaining <= I_ThreadInfo.length;
         end else if (w_re) begin
            r_ptr       <= r_ptr + WIDTH_ADDR'(1);
            r_remaining <= r_remaining - WIDTH_ADDR'(1);
         end
      end
   end

   mpu_fetch_skid #(
      .WIDTH   (WIDTH_INSTR)
   ) u_skid (
      .clock   (clock),
      .reset   (reset),
      .i_push  (r_inflight),
      .i_data  (I_IMem_Data),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_count (w_fifo_count),
      .o_valid (w_fifo_valid)
   );

   assign O_Ack_Dispatch = w_accept;
   assign O_Req_Lookup   = (r_state == LOOKUP);
   assign O_ThreadID_Ld  = r_thread_id;
   assign O_IMem_Re      = w_re;
   assign O_IMem_Addr    = r_ptr;
   assign O_Instr_Valid  = w_fifo_valid;
   assign O_Instr        = w_fifo_data;
   assign O_Busy         = (r_state != IDLE);
   assign O_Done         = r_done;

endmodule
`default_nettype wire

// File: doc/mpu_lookup_fetch.md
# mpu_lookup_fetch

Dispatch-side initiator of the MPU thread map-table lookup protocol. It accepts a dispatch command carrying a thread ID, issues a lookup to the map manager and captures the returned program address and length. It then streams that many instruction words from instruction memory to the downstream sequencer through a valid/ready port, with a 2-entry buffer absorbing the memory read latency and any backpressure.

## Interface
Parameters:
- WIDTH_ID, 8: thread ID width (matches `id_t`)
- WIDTH_ADDR, 10: instruction-memory address/length width (matches `mpu_address_t`)
- WIDTH_INSTR, 32: instruction word width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- I_Req_Dispatch  in  1  dispatch command valid
- I_ThreadID  in  WIDTH_ID  thread to launch
- O_Ack_Dispatch  out  1  command accepted (one cycle)
- O_Req_Lookup  out  1  lookup request to map manager
- O_ThreadID_Ld  out  WIDTH_ID  thread ID for lookup (latched)
- I_Ack_Lookup  in  1  lookup response valid
- I_ThreadInfo  in  lookup_t  {address, length} of the thread program
- O_IMem_Re  out  1  instruction memory read enable
- O_IMem_Addr  out  WIDTH_ADDR  read address
- I_IMem_Data  in  WIDTH_INSTR  read data, fixed 1-cycle latency
- O_Instr_Valid  out  1  instruction word valid
- O_Instr  out  WIDTH_INSTR  instruction word
- I_Instr_Ready  in  1  downstream accepts word
- O_Busy  out  1  high in any state other than IDLE
- O_Done  out  1  one-cycle pulse: program fully delivered

## Operation
- FSM states: IDLE, LOOKUP, FETCH, DRAIN.
- IDLE:
  - O_Ack_Dispatch = I_Req_Dispatch.
  - On request, latch I_ThreadID into O_ThreadID_Ld and go to LOOKUP.
  - Requests in other states are not acknowledged.
- LOOKUP:
  - O_Req_Lookup held high until I_Ack_Lookup is sampled high; ThreadInfo is captured that cycle.
  - O_Req_Lookup is low from the next cycle.
  - length==0: pulse O_Done next cycle and go to IDLE, with no reads.
  - Otherwise set ptr=address, remaining=length and go to FETCH.
- FETCH:
  - O_IMem_Re = (remaining!=0) & (count + inflight - pop < 2). Here count is buffer occupancy, inflight is 1 if a read was issued last cycle, and pop = O_Instr_Valid & I_Instr_Ready.
  - O_IMem_Addr = ptr. Each read increments ptr modulo 2^WIDTH_ADDR (wrap-around) and decrements remaining.
  - Go to DRAIN in the cycle after the read that takes remaining to 0.
- DRAIN:
  - When count==0, inflight==0 and no pop is pending, go to IDLE.
  - O_Done pulses in that next (IDLE) cycle.
- Data path: I_IMem_Data is written into the 2-entry FIFO on the cycle after the read. The FIFO head drives O_Instr/O_Instr_Valid. Simultaneous push and pop is legal in every occupancy, including full-with-pop.
- The credit rule guarantees no FIFO overflow. Words are delivered in address order, exactly `length` words.

## Timing
- Reset values: all outputs 0; FSM=IDLE; counters, ptr and FIFO cleared. Reset mid-operation abandons the transfer with no O_Done and no further reads.
- Dispatch accepted in cycle 0 → O_Req_Lookup high from cycle 1.
- Lookup ack in cycle k → first O_IMem_Re in k+1 → data captured at end of k+2 → first O_Instr_Valid in k+3.
- With I_Instr_Ready held high: one word per cycle, and the last word appears in cycle k+2+length.
- O_Done is asserted the cycle after the final handshake. The next dispatch can be acknowledged in that same cycle.
- Ready low: reads stop after at most 2 words are outstanding or buffered. O_Instr is held stable while valid and not ready.

## Structure
- `pkg_mpu`:
  - Existing: `id_t`, `mpu_address_t`, `lookup_t`.
  - New: `instr_t` and the `fsm_lookup_fetch` enum (IDLE/LOOKUP/FETCH/DRAIN).
- Sub-module `mpu_fetch_skid`: 2-entry synchronous FIFO (push, pop, data, count, valid) with the same async active-low reset.

## Test plan
- Dispatch ID 5; lookup acked after 3 cycles with {address=0x10, length=4}, ready high → reads 0x10–0x13 on consecutive cycles, 4 words in order, O_Done 1 cycle after the 4th, O_Busy then low.
- length=0 → no O_IMem_Re, O_Done the cycle after I_Ack_Lookup, FSM back in IDLE.
- {address=0x3FE, length=4} with WIDTH_ADDR=10 → addresses 0x3FE, 0x3FF, 0x000, 0x001.
- length=8, I_Instr_Ready toggled 1,0,0,1,… → never more than 2 words outstanding or buffered, no word lost or duplicated, O_Instr stable while stalled.
- Second I_Req_Dispatch during FETCH → O_Ack_Dispatch stays low until O_Done, then is accepted in the O_Done cycle.
- reset driven low in the middle of FETCH → all outputs 0 immediately, no O_Done. After release, a fresh dispatch runs normally.
